// File: rtl/imm_encode_if.sv
// ---------------------------------------------------------------
// imm_encode_if : request/response handshake bundle for imm_encode
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

interface imm_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic [2:0]  in_immsrc;
  logic [31:0] in_tmpl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid, in_imm, in_immsrc, in_tmpl, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_imm, in_immsrc, in_tmpl, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

`default_nettype wire

// File: rtl/imm_encode.sv
// ---------------------------------------------------------------
// imm_encode : scatters an immediate into RV32I instruction fields
//              behind a one-deep valid/ready output register
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module imm_encode #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  imm_encode_if.slave      bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;

  logic [31:0] imm;
  logic [31:0] field;
  logic [31:0] mask;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        sext11;
  logic        sext12;
  logic        sext20;
  logic        accept;
  logic        valid_q;
  logic [31:0] instr_q;
  logic        err_q;

  assign imm = bus.in_imm;

  // An upper slice that is all-ones or all-zeros means the value fits the field.
  assign sext11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign sext12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign sext20 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    field   = {imm[11:0], 20'b0};
    mask    = 32'hFFF0_0000;
    enc_err = ~sext11 | (bus.in_immsrc != FMT_I);
    case (bus.in_immsrc)
      FMT_S: begin
        field   = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        mask    = 32'hFE00_0F80;
        enc_err = ~sext11;
      end
      FMT_B: begin
        field   = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        mask    = 32'hFE00_0F80;
        enc_err = ~sext12 | imm[0];
      end
      FMT_J: begin
        field   = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        mask    = 32'hFFFF_F000;
        enc_err = ~sext20 | imm[0];
      end
      FMT_U: begin
        field   = {imm[31:12], 12'b0};
        mask    = 32'hFFFF_F000;
        enc_err = |imm[11:0];
      end
      default: begin
        field   = {imm[11:0], 20'b0};
        mask    = 32'hFFF0_0000;
        enc_err = ~sext11 | (bus.in_immsrc != FMT_I);
      end
    endcase
    enc_word = (bus.in_tmpl & ~mask) | field;
  end

  assign bus.in_ready = ~valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      instr_q <= enc_word;
      err_q   <= enc_err;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_err   = err_q;

  // Clear takes priority, so a request landing on the clear edge is not counted.
  always_ff @(posedge clk) begin
    if (!reset_n || cnt_clr) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (accept) begin
      enc_count <= enc_count + CNT_W'(1);
      if (enc_err && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire
